alu_response_checker: RTL and testbench

- Self-checking scoreboard on the response side of the 16-bit ALU interface; the stimulus driver is the initiator.
- Each cycle `Valid` is high, it samples the operands and control driven into the ALU together with the ALU's Result/Zero/CarryOut.
- It recomputes the golden result internally, compares, and keeps pass/fail counters plus a first-failure capture.
- A small run FSM bounds each check session to NUM_VECTORS vectors and reports Done/Pass, so datapath benches and on-board self-test end with a single verdict.

---
 rtl/alu_response_checker.sv | 179 +++++++++++++++++
 tb/tb_alu_response_checker.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_response_checker.sv
// Response-side scoreboard for the 16-bit ALU: recomputes the golden result for each
// accepted vector, counts pass/fail, captures the first failure and reports a run verdict.
module alu_response_checker #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned NUM_VECTORS = 8
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             Start,
    input  logic             Valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       ALUOp,
    input  logic             BNegate,
    input  logic [WIDTH-1:0] Result,
    input  logic             Zero,
    input  logic             CarryOut,
    output logic             Busy,
    output logic             Done,
    output logic             Pass,
    output logic [CNT_W-1:0] PassCount,
    output logic [CNT_W-1:0] FailCount,
    output logic [CNT_W-1:0] FailIndex,
    output logic [WIDTH-1:0] FailExpected
);

    localparam logic [CNT_W-1:0] NumVec = CNT_W'(NUM_VECTORS);
    localparam logic [CNT_W-1:0] CntMax = '1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] acc_q;
    logic [CNT_W-1:0] chk_q;

    // Stage 1: captured stimulus/response pair
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [1:0]       s1_op_q;
    logic             s1_bneg_q;
    logic [WIDTH-1:0] s1_result_q;
    logic             s1_zero_q;
    logic             s1_carry_q;
    logic [CNT_W-1:0] s1_idx_q;

    // Stage 2: registered compare outcome
    logic             s2_valid_q;
    logic             s2_fail_q;
    logic [CNT_W-1:0] s2_idx_q;
    logic [WIDTH-1:0] s2_exp_q;

    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [CNT_W-1:0] pass_cnt_q;
    logic [CNT_W-1:0] fail_cnt_q;
    logic [CNT_W-1:0] fail_idx_q;
    logic [WIDTH-1:0] fail_exp_q;

    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] exp_r;
    logic             exp_z;
    logic             exp_c;
    logic             mismatch;
    logic             accept;

    assign accept = (state_q == StRun) && Valid && !Start && (acc_q < NumVec);

    always_comb begin
        bx    = s1_bneg_q ? ~s1_b_q : s1_b_q;
        sum   = {1'b0, s1_a_q} + {1'b0, bx} + {{WIDTH{1'b0}}, s1_bneg_q};
        exp_r = '0;
        unique case (s1_op_q)
            2'b00: exp_r = s1_a_q & bx;
            2'b01: exp_r = s1_a_q | bx;
            2'b10: exp_r = sum[WIDTH-1:0];
            2'b11: exp_r = s1_a_q ^ bx;
            default: exp_r = '0;
        endcase
        exp_c = sum[WIDTH];
        exp_z = (exp_r == '0);
        // Carry is only meaningful for the adder path
        mismatch = (s1_result_q != exp_r) || (s1_zero_q != exp_z) ||
                   ((s1_op_q == 2'b10) && (s1_carry_q != exp_c));
    end

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            chk_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= '0;
            s1_bneg_q   <= 1'b0;
            s1_result_q <= '0;
            s1_zero_q   <= 1'b0;
            s1_carry_q  <= 1'b0;
            s1_idx_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_fail_q   <= 1'b0;
            s2_idx_q    <= '0;
            s2_exp_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            pass_cnt_q  <= '0;
            fail_cnt_q  <= '0;
            fail_idx_q  <= '0;
            fail_exp_q  <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_a_q      <= A;
                s1_b_q      <= B;
                s1_op_q     <= ALUOp;
                s1_bneg_q   <= BNegate;
                s1_result_q <= Result;
                s1_zero_q   <= Zero;
                s1_carry_q  <= CarryOut;
                s1_idx_q    <= acc_q;
                acc_q       <= acc_q + 1'b1;
            end
            s2_valid_q <= s1_valid_q;
            s2_fail_q  <= mismatch;
            s2_idx_q   <= s1_idx_q;
            s2_exp_q   <= exp_r;

            if (s2_valid_q) begin
                chk_q <= chk_q + 1'b1;
                if (s2_fail_q) begin
                    if (fail_cnt_q != CntMax) fail_cnt_q <= fail_cnt_q + 1'b1;
                    if (fail_cnt_q == '0) begin
                        fail_idx_q <= s2_idx_q;
                        fail_exp_q <= s2_exp_q;
                    end
                end else if (pass_cnt_q != CntMax) begin
                    pass_cnt_q <= pass_cnt_q + 1'b1;
                end
            end

            if ((state_q == StRun) && (chk_q == NumVec)) begin
                state_q <= StDone;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                pass_q  <= (fail_cnt_q == '0);
            end

            // Start wins over everything else and discards in-flight vectors
            if (Start) begin
                state_q    <= StRun;
                busy_q     <= 1'b1;
                done_q     <= 1'b0;
                pass_q     <= 1'b0;
                acc_q      <= '0;
                chk_q      <= '0;
                s1_valid_q <= 1'b0;
                s2_valid_q <= 1'b0;
                pass_cnt_q <= '0;
                fail_cnt_q <= '0;
                fail_idx_q <= '0;
                fail_exp_q <= '0;
            end
        end
    end

    assign Busy         = busy_q;
    assign Done         = done_q;
    assign Pass         = pass_q;
    assign PassCount    = pass_cnt_q;
    assign FailCount    = fail_cnt_q;
    assign FailIndex    = fail_idx_q;
    assign FailExpected = fail_exp_q;

endmodule

// File: tb/tb_alu_response_checker.sv
// Directed bench for alu_response_checker: a 4-vector instance and a 2-bit-counter
// instance share stimulus; each run is checked against hand-computed values.
module tb_alu_response_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_m;
    logic        start_s;
    logic        valid;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic        bneg;
    logic [15:0] res;
    logic        zero;
    logic        carry;

    logic        busy_m, done_m, pass_m;
    logic [15:0] pcnt_m, fcnt_m, fidx_m, fexp_m;
    logic        busy_s, done_s, pass_s;
    logic [1:0]  pcnt_s, fcnt_s, fidx_s;
    logic [15:0] fexp_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_response_checker #(.WIDTH(16), .CNT_W(16), .NUM_VECTORS(4)) u_dut (
        .Clock(clk), .ResetN(rst_n), .Start(start_m), .Valid(valid),
        .A(a), .B(b), .ALUOp(op), .BNegate(bneg),
        .Result(res), .Zero(zero), .CarryOut(carry),
        .Busy(busy_m), .Done(done_m), .Pass(pass_m),
        .PassCount(pcnt_m), .FailCount(fcnt_m), .FailIndex(fidx_m),
        .FailExpected(fexp_m)
    );

    alu_response_checker #(.WIDTH(16), .CNT_W(2), .NUM_VECTORS(3)) u_sat (
        .Clock(clk), .ResetN(rst_n), .Start(start_s), .Valid(valid),
        .A(a), .B(b), .ALUOp(op), .BNegate(bneg),
        .Result(res), .Zero(zero), .CarryOut(carry),
        .Busy(busy_s), .Done(done_s), .Pass(pass_s),
        .PassCount(pcnt_s), .FailCount(fcnt_s), .FailIndex(fidx_s),
        .FailExpected(fexp_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Holds one vector on the inputs across a rising edge, returns 1ns after it
    task automatic vec(input logic [1:0] o, input logic bn, input logic [15:0] va,
                       input logic [15:0] vb, input logic [15:0] r, input logic z,
                       input logic c);
        valid = 1'b1; op = o; bneg = bn; a = va; b = vb; res = r; zero = z; carry = c;
        @(posedge clk); #1;
    endtask

    task automatic idle_cycles(input int n);
        valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_start_m();
        start_m = 1'b1;
        @(posedge clk); #1;
        start_m = 1'b0;
    endtask

    task automatic pulse_start_s();
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
    endtask

    task automatic good_four();
        vec(2'b00, 1'b0, 16'd5, 16'd5, 16'd5, 1'b0, 1'b0);
        vec(2'b01, 1'b0, 16'd6, 16'd3, 16'd7, 1'b0, 1'b0);
        vec(2'b10, 1'b0, 16'd10, 16'd20, 16'd30, 1'b0, 1'b0);
        vec(2'b10, 1'b1, 16'd10, 16'd10, 16'd0, 1'b1, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; start_m = 1'b0; start_s = 1'b0; valid = 1'b0;
        a = '0; b = '0; op = '0; bneg = 1'b0; res = '0; zero = 1'b0; carry = 1'b0;
        idle_cycles(2);
        check("rst_busy", busy_m, 0);
        check("rst_done", done_m, 0);
        check("rst_pass", pass_m, 0);
        check("rst_pcnt", pcnt_m, 0);
        check("rst_fcnt", fcnt_m, 0);
        rst_n = 1'b1;

        // Valid in IDLE (deliberately wrong) must be ignored
        vec(2'b00, 1'b0, 16'd1, 16'd1, 16'd9, 1'b0, 1'b0);
        idle_cycles(3);
        check("idle_fcnt", fcnt_m, 0);
        check("idle_busy", busy_m, 0);

        // Run 1: four good vectors plus two wrong extras that must not be counted
        pulse_start_m();
        check("r1_busy", busy_m, 1);
        good_four();
        vec(2'b00, 1'b0, 16'd1, 16'd1, 16'd9, 1'b0, 1'b0);
        vec(2'b00, 1'b0, 16'd1, 16'd1, 16'd9, 1'b0, 1'b0);
        valid = 1'b0;
        check("r1_done_early", done_m, 0);
        check("r1_pcnt_early", pcnt_m, 4);
        @(posedge clk); #1;
        check("r1_done", done_m, 1);
        check("r1_pass", pass_m, 1);
        check("r1_pcnt", pcnt_m, 4);
        check("r1_fcnt", fcnt_m, 0);
        check("r1_busy_off", busy_m, 0);
        vec(2'b00, 1'b0, 16'd1, 16'd1, 16'd9, 1'b0, 1'b0);
        idle_cycles(3);
        check("r1_hold_fcnt", fcnt_m, 0);
        check("r1_hold_done", done_m, 1);
        check("r1_hold_pass", pass_m, 1);

        // Run 2: carry don't-care on AND, XOR bad at idx 2, SUB with bad carry at idx 3
        pulse_start_m();
        check("r2_clr_done", done_m, 0);
        check("r2_clr_pcnt", pcnt_m, 0);
        vec(2'b00, 1'b0, 16'd5, 16'd5, 16'd5, 1'b0, 1'b1);
        vec(2'b10, 1'b0, 16'd1, 16'd1, 16'd2, 1'b0, 1'b0);
        vec(2'b11, 1'b0, 16'd6, 16'd3, 16'd4, 1'b0, 1'b0);
        vec(2'b10, 1'b1, 16'd40, 16'd30, 16'd10, 1'b0, 1'b0);
        idle_cycles(3);
        check("r2_done", done_m, 1);
        check("r2_pass", pass_m, 0);
        check("r2_pcnt", pcnt_m, 2);
        check("r2_fcnt", fcnt_m, 2);
        check("r2_fidx", fidx_m, 2);
        check("r2_fexp", fexp_m, 5);

        // Run 3: reset after two vectors abandons the run
        pulse_start_m();
        vec(2'b00, 1'b0, 16'd5, 16'd5, 16'd5, 1'b0, 1'b0);
        vec(2'b11, 1'b0, 16'd6, 16'd3, 16'd4, 1'b0, 1'b0);
        valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mrst_busy", busy_m, 0);
        check("mrst_done", done_m, 0);
        check("mrst_pcnt", pcnt_m, 0);
        check("mrst_fcnt", fcnt_m, 0);
        check("mrst_fidx", fidx_m, 0);
        check("mrst_fexp", fexp_m, 0);
        rst_n = 1'b1;
        idle_cycles(4);
        check("mrst_stay_idle", done_m, 0);
        pulse_start_m();
        good_four();
        idle_cycles(3);
        check("r4_done", done_m, 1);
        check("r4_pass", pass_m, 1);
        check("r4_pcnt", pcnt_m, 4);

        // Narrow-counter instance: every vector wrong (AND 1&1 reported 0)
        pulse_start_s();
        for (int i = 0; i < 3; i++) vec(2'b00, 1'b0, 16'd1, 16'd1, 16'd0, 1'b1, 1'b0);
        idle_cycles(3);
        check("s1_done", done_s, 1);
        check("s1_fcnt", fcnt_s, 3);
        check("s1_pcnt", pcnt_s, 0);
        check("s1_pass", pass_s, 0);
        check("s1_fexp", fexp_s, 1);
        pulse_start_s();
        for (int i = 0; i < 5; i++) vec(2'b00, 1'b0, 16'd1, 16'd1, 16'd0, 1'b1, 1'b0);
        idle_cycles(4);
        check("s2_fcnt_nowrap", fcnt_s, 3);
        check("s2_fidx", fidx_s, 0);
        check("s2_done", done_s, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
